// File: rtl/ram_arbiter.sv
// ram_arbiter
// Shares one single-port RAM (registered read address) between requester A
// and requester B. At most one access is granted per cycle, and bursts are
// capped at MAX_BURST consecutive grants.
//
// Optional feature macro: RAM_ARB_RR_EN
//   defined   : round-robin arbitration (the side that was not granted last wins)
//   undefined : fixed priority (A always wins an arbitration point)
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   req_x, we_x, addr_x, wdata_x  requester X access (held until granted)
//   gnt_x                       combinational grant, same cycle as req
//   rdata_x, rvalid_x           registered read return, 2 cycles after grant
//   ram_addr, ram_data, ram_we  RAM command (all zero when nothing is granted)
//   ram_q                       RAM read data for the address registered last edge

module ram_arbiter #(
  parameter int unsigned AW        = 6,
  parameter int unsigned DW        = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_a,
  input  logic          we_a,
  input  logic [AW-1:0] addr_a,
  input  logic [DW-1:0] wdata_a,
  input  logic          req_b,
  input  logic          we_b,
  input  logic [AW-1:0] addr_b,
  input  logic [DW-1:0] wdata_b,
  output logic          gnt_a,
  output logic          gnt_b,
  output logic [DW-1:0] rdata_a,
  output logic [DW-1:0] rdata_b,
  output logic          rvalid_a,
  output logic          rvalid_b,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_data,
  output logic          ram_we,
  input  logic [DW-1:0] ram_q
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    OWN_IDLE = 2'd0,
    OWN_A    = 2'd1,
    OWN_B    = 2'd2
  } owner_t;

  owner_t           owner;
  logic [CNT_W-1:0] burst_cnt;
  logic             last_b;     // 1: B was granted last, 0: A was granted last
  logic             pending_a;
  logic             pending_b;

  logic cont_a;
  logic cont_b;
  logic sel_a;
  logic sel_b;
  logic arb_a;                  // winner when both sides meet at an arbitration point

  // Arbitration policy for simultaneous requests outside a running burst
`ifdef RAM_ARB_RR_EN
  assign arb_a = last_b;
`else
  logic unused_last;
  assign arb_a       = 1'b1;
  assign unused_last = last_b;
`endif

  // Requester selection: a running burst continues first, otherwise arbitrate
  always_comb begin
    cont_a = 1'b0;
    cont_b = 1'b0;
    sel_a  = 1'b0;
    sel_b  = 1'b0;
    cont_a = (owner == OWN_A) && req_a && (burst_cnt < BURST_MAX);
    cont_b = (owner == OWN_B) && req_b && (burst_cnt < BURST_MAX);
    if (cont_a) begin
      sel_a = 1'b1;
    end else if (cont_b) begin
      sel_b = 1'b1;
    end else if (req_a && req_b) begin
      sel_a = arb_a;
      sel_b = !arb_a;
    end else begin
      sel_a = req_a;
      sel_b = req_b;
    end
  end

  // Grants are suppressed while reset is asserted
  assign gnt_a = sel_a & rst_n;
  assign gnt_b = sel_b & rst_n;

  // RAM command mux
  always_comb begin
    ram_addr = '0;
    ram_data = '0;
    ram_we   = 1'b0;
    if (gnt_a) begin
      ram_addr = addr_a;
      ram_data = wdata_a;
      ram_we   = we_a;
    end else if (gnt_b) begin
      ram_addr = addr_b;
      ram_data = wdata_b;
      ram_we   = we_b;
    end
  end

  // Ownership, burst length and last-granted tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner     <= OWN_IDLE;
      burst_cnt <= '0;
      last_b    <= 1'b1;
    end else if (gnt_a) begin
      owner     <= OWN_A;
      last_b    <= 1'b0;
      burst_cnt <= cont_a ? burst_cnt + CNT_ONE : CNT_ONE;
    end else if (gnt_b) begin
      owner     <= OWN_B;
      last_b    <= 1'b1;
      burst_cnt <= cont_b ? burst_cnt + CNT_ONE : CNT_ONE;
    end else begin
      owner     <= OWN_IDLE;
      burst_cnt <= '0;
    end
  end

  // Read return: the RAM presents data one cycle after the address edge,
  // so a read granted in N is captured at the edge ending N+1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_a <= 1'b0;
      pending_b <= 1'b0;
      rvalid_a  <= 1'b0;
      rvalid_b  <= 1'b0;
      rdata_a   <= '0;
      rdata_b   <= '0;
    end else begin
      pending_a <= gnt_a & ~we_a;
      pending_b <= gnt_b & ~we_b;
      rvalid_a  <= pending_a;
      rvalid_b  <= pending_b;
      if (pending_a) begin
        rdata_a <= ram_q;
      end
      if (pending_b) begin
        rdata_b <= ram_q;
      end
    end
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-requester arbiter that shares one 64x8 single-port RAM with registered read address between requester A and requester B. It grants at most one access per cycle, drives the RAM address/data/write-enable, and returns read data to the requester that issued the read. It bounds each burst so neither side can hold the RAM indefinitely. It sits directly in front of the single-port RAM, and both requesters connect only to this block.

## Interface
- AW, 6: address width.
- DW, 8: data width.
- MAX_BURST, 4: maximum consecutive grants to one requester while the other is waiting (range 1..15).

- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_a / req_b  in  1  access request; held until granted.
- we_a / we_b  in  1  1 = write, 0 = read; valid with req.
- addr_a / addr_b  in  AW  access address.
- wdata_a / wdata_b  in  DW  write data.
- gnt_a / gnt_b  out  1  combinational; access accepted this cycle.
- rdata_a / rdata_b  out  DW  registered read data.
- rvalid_a / rvalid_b  out  1  registered; rdata valid this cycle.
- ram_addr  out  AW  to RAM addr.
- ram_data  out  DW  to RAM data.
- ram_we  out  1  to RAM we.
- ram_q  in  DW  from RAM q (RAM content at the address registered last edge).

## Operation
- State: owner ∈ {IDLE, OWN_A, OWN_B}, burst_cnt (4 bits), last (last granted side).
- Selection (combinational, each cycle):
  - If owner = OWN_X, req_x = 1, and burst_cnt < MAX_BURST, then select X (burst continues).
  - Otherwise, arbitrate among the active requests per policy (see Configuration).
  - If no request is active, select none.
- gnt_x = 1 exactly when X is selected; at most one grant per cycle.
- Granted access drives ram_addr/ram_data/ram_we from that side. With no grant: ram_we = 0, ram_addr = 0, ram_data = 0.
- Edge update when X is granted:
  - owner ← OWN_X; last ← X.
  - burst_cnt ← burst_cnt+1 if X continues its burst, else 1.
- Edge update with no grant: owner ← IDLE, burst_cnt ← 0.
- Burst end:
  - If req_x drops, ownership is released.
  - If burst_cnt reaches MAX_BURST and the other side requests, the other side wins.
  - If burst_cnt reaches MAX_BURST and the other side is idle, X is re-granted with burst_cnt = 1.
- Reads: a read accepted in cycle N sets pending_x.
  - At the edge ending N+1: rdata_x ← ram_q, rvalid_x ← 1 for one cycle.
  - rdata_x holds its value while rvalid_x = 0.
- Read-after-write to the same address in consecutive grants returns the new data.
- A write accepted in N+1 is not visible to a read accepted in N.
- Back-to-back reads from either side pipeline fully; one result per cycle.

## Timing
- Reset (rst_n low):
  - owner = IDLE, burst_cnt = 0, last = B.
  - pending_a/b = 0, rvalid_a/b = 0, rdata_a/b = 0.
  - gnt_a/b forced 0 and ram_we forced 0 regardless of req.
- Grant latency: 0 cycles (same cycle as req, if selected).
- Read latency: rvalid 2 cycles after the grant cycle.
- Reset mid-burst or with a read pending: the pending read is discarded, no rvalid is produced, and arbitration restarts from IDLE on the first edge after rst_n rises.
- Simultaneous first requests from IDLE resolve per policy; with last = B after reset, A wins.

## Configuration
- RAM_ARB_RR_EN defined: round-robin. At an arbitration point with both requesting, the side ≠ last wins. Neither side can starve; worst-case wait is MAX_BURST cycles.
- RAM_ARB_RR_EN undefined: fixed priority. A always wins arbitration points. MAX_BURST still caps B's bursts, but A's burst cap only yields to B when A has no request, so B may starve.

## Test plan
- Single write then read: A writes 0x5A to addr 0x10 (gnt_a same cycle), then A reads 0x10 → rvalid_a 2 cycles after the read grant, rdata_a = 0x5A; ram_we = 0 in the read cycle.
- Contention, RR build: A and B both hold req continuously, MAX_BURST = 4 → grants alternate A×4, B×4, A×4; no cycle without a grant; gnt_a & gnt_b never both 1.
- Contention, fixed build: same stimulus → A granted every cycle, gnt_b = 0 throughout. Then drop req_a → gnt_b = 1 in the same cycle.
- Interleaved reads: B reads 0x01 and 0x02 back-to-back (preloaded 0x11/0x22) while A writes 0x3F with 0x77 → rvalid_b on two consecutive cycles, data 0x11 then 0x22; rvalid_a stays 0.
- Reset mid-operation: grant a read to A, assert rst_n low the next cycle → rvalid_a stays 0, gnt_a/gnt_b = 0 during reset even with req high; after release, both requesting → A is granted first.
- Solo burst: only A requests for 10 cycles → gnt_a high for all 10 cycles; burst_cnt wraps 4 → 1 with no gap.
